sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 256Kx16 async SRAM between two requesters.
- Port V is the background layer's read-only line fetch. Port H is a host/loader read-write port used for tile, map and palette uploads.
- Fixed priority goes to video, with a starvation guard that forces a host slot after a run of video grants.
- Sits between the background layer / host logic and the top-level ram_* pins.

Parameters:
ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access; legal range 2..15.
HOST_SLOT, 8, number of consecutive video grants, with host_req pending, after which host wins the next arbitration; legal range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video read request; held high until vid_ack
vid_addr  in  18  video word address; stable while vid_req high
vid_ack  out  1  one-cycle pulse; vid_rdata valid in the same cycle
vid_rdata  out  16  video read data; holds until the next video read
host_req  in  1  host request; held high until host_ack
host_we  in  1  1 = write, 0 = read; stable while host_req high
host_addr  in  18  host word address; stable while host_req high
host_wdata  in  16  host write data
host_be  in  2  byte enables, [1] = high byte, [0] = low byte
host_ack  out  1  one-cycle pulse; access complete, host_rdata valid for reads
host_rdata  out  16  host read data; holds until the next host read
busy  out  1  high in any state other than IDLE
ram_addr  out  18  SRAM address
ram_din  in  16  SRAM read data
ram_dout  out  16  SRAM write data; the top level enables its tristate while ram_we is low
ram_ce  out  1  chip enable, active-low
ram_oe  out  1  output enable, active-low
ram_we  out  1  write enable, active-low
ram_lb  out  1  low byte enable, active-low
ram_hb  out  1  high byte enable, active-low

Behaviour:
- All outputs are registered.
- State machine states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples the requests each cycle.
  - If only one request is high, that port is granted.
  - If both are high, video is granted unless starve_cnt == HOST_SLOT, in which case host is granted.
  - On a grant, the address, direction, byte enables and write data are latched, and the state goes to ACCESS with the cycle counter at 0.
- ACCESS lasts exactly ACCESS_CYCLES cycles:
  - ram_ce = 0 throughout. ram_addr = latched address.
  - Read: ram_oe = 0 and ram_lb = ram_hb = 0 throughout; ram_we = 1.
  - Write: ram_oe = 1, ram_dout = latched data, {ram_hb, ram_lb} = ~be throughout. ram_we = 0 from the second ACCESS cycle to the last, which gives one cycle of address setup.
  - Read data is captured from ram_din at the clock edge that ends the last ACCESS cycle, into vid_rdata or host_rdata.
- DONE lasts 1 cycle:
  - All strobes are high (this is the write-recovery / bus-turnaround cycle).
  - The ack of the granted port pulses high.
  - The next state is IDLE. The requester must drop req at the edge following its ack, so no double grant can occur.
- Latency: request sampled in IDLE at cycle t → strobes active in cycles t+1..t+ACCESS_CYCLES → ack in cycle t+ACCESS_CYCLES+1. This gives a throughput of one access per ACCESS_CYCLES+2 cycles.
- starve_cnt is 8 bits wide:
  - Increments on each video grant while host_req is high, saturating at HOST_SLOT.
  - Clears on any host grant, or on any cycle in which host_req is low.
- ram_addr and ram_dout hold their last values when idle; only the strobes return high.
- Reset, including in the middle of an access:
  - On the next edge the state is IDLE and ram_ce/oe/we/lb/hb = 1.
  - ram_addr = 0, ram_dout = 0, vid_ack = host_ack = 0, vid_rdata = host_rdata = 0, starve_cnt = 0, busy = 0.
  - No ack is issued for the aborted access.
- A request that rises while another access is in progress waits; it is only evaluated in IDLE.

Test Plan:
- Video read, ACCESS_CYCLES=2: memory model holds 0xBEEF at 0x01234. Pulse vid_req with vid_addr=0x01234 at cycle 0 → ram_ce/ram_oe low in cycles 1–2, ram_we high, vid_ack in cycle 3 with vid_rdata=0xBEEF.
- Host byte write: host_we=1, host_addr=0x3FFFF, host_wdata=0xA55A, host_be=2'b01 → ram_lb=0, ram_hb=1 throughout ACCESS, ram_we low only in the second ACCESS cycle, ram_dout=0xA55A; the model then reads 0x??5A with the high byte unchanged; host_ack pulses once.
- Simultaneous requests: vid_req and host_req rise together, both held → video is granted first; host is granted on the next IDLE, with host_ack 4 cycles after vid_ack.
- Starvation, HOST_SLOT=8: vid_req is re-asserted immediately after each ack and host_req is held high → exactly 8 video acks, then a host ack, then video resumes.
- Reset mid-access: assert reset in the first ACCESS cycle of a host write → on the next edge all strobes are high, busy=0, and no host_ack ever appears; after reset a fresh video read completes with normal latency.
- Host read-back: write 0x1357 to 0x00010 with be=2'b11, then read 0x00010 → host_rdata=0x1357 on host_ack, and vid_rdata is unchanged.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 256Kx16 async SRAM between the video
// line fetch (read-only, fixed priority) and a host read/write port. A
// starvation guard hands the host a slot after HOST_SLOT back-to-back video
// grants made while the host was waiting. Every output is registered.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,   // 2..15
    parameter int HOST_SLOT     = 8    // 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [17:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [17:0] host_addr,
    input  logic [15:0] host_wdata,
    input  logic [1:0]  host_be,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        busy,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_din,
    output logic [15:0] ram_dout,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        ram_lb,
    output logic        ram_hb
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
    localparam logic [7:0] SLOT_CNT = 8'(HOST_SLOT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        host_q, host_d;     // current grant belongs to host
    logic        we_q, we_d;         // current access is a write
    logic [17:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, lb_q, lb_d, hb_q, hb_d;
    logic        vack_q, vack_d, hack_q, hack_d;
    logic [15:0] vrd_q, vrd_d, hrd_q, hrd_d;
    logic [7:0]  starve_q, starve_d;
    logic        busy_q, busy_d;

    logic        grant_v, grant_h;
    logic        grant_we;
    logic [1:0]  grant_be;

    // Arbitration: video wins unless the host has waited out its slot.
    always_comb begin
        grant_v  = 1'b0;
        grant_h  = 1'b0;
        grant_we = 1'b0;
        grant_be = 2'b11;
        if (state_q == S_IDLE) begin
            grant_v = vid_req && !(host_req && starve_q == SLOT_CNT);
            grant_h = host_req && !grant_v;
        end
        if (grant_h && host_we) begin
            grant_we = 1'b1;
            grant_be = host_be;      // reads always enable both bytes
        end
    end

    // Next-state for the FSM and every registered output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        host_d   = host_q;
        we_d     = we_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        ce_d     = ce_q;
        oe_d     = oe_q;
        wen_d    = wen_q;
        lb_d     = lb_q;
        hb_d     = hb_q;
        vack_d   = 1'b0;
        hack_d   = 1'b0;
        vrd_d    = vrd_q;
        hrd_d    = hrd_q;
        busy_d   = busy_q;
        starve_d = starve_q;

        case (state_q)
            S_IDLE: begin
                if (grant_v || grant_h) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    host_d  = grant_h;
                    we_d    = grant_we;
                    addr_d  = grant_h ? host_addr : vid_addr;
                    if (grant_h)
                        dout_d = host_wdata;
                    ce_d  = 1'b0;
                    oe_d  = grant_we;
                    wen_d = 1'b1;    // first ACCESS cycle is address setup
                    lb_d  = ~grant_be[0];
                    hb_d  = ~grant_be[1];
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    lb_d    = 1'b1;
                    hb_d    = 1'b1;
                    if (host_q) begin
                        hack_d = 1'b1;
                        if (!we_q)
                            hrd_d = ram_din;
                    end else begin
                        vack_d = 1'b1;
                        vrd_d  = ram_din;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (we_q)
                        wen_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Starvation counter only tracks a continuously waiting host.
        if (!host_req || grant_h)
            starve_d = 8'd0;
        else if (grant_v && starve_q != SLOT_CNT)
            starve_d = starve_q + 8'd1;
    end

    // State and output registers; reset aborts any access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            host_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 18'd0;
            dout_q   <= 16'd0;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            wen_q    <= 1'b1;
            lb_q     <= 1'b1;
            hb_q     <= 1'b1;
            vack_q   <= 1'b0;
            hack_q   <= 1'b0;
            vrd_q    <= 16'd0;
            hrd_q    <= 16'd0;
            starve_q <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            host_q   <= host_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            wen_q    <= wen_d;
            lb_q     <= lb_d;
            hb_q     <= hb_d;
            vack_q   <= vack_d;
            hack_q   <= hack_d;
            vrd_q    <= vrd_d;
            hrd_q    <= hrd_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    assign vid_ack    = vack_q;
    assign vid_rdata  = vrd_q;
    assign host_ack   = hack_q;
    assign host_rdata = hrd_q;
    assign busy       = busy_q;
    assign ram_addr   = addr_q;
    assign ram_dout   = dout_q;
    assign ram_ce     = ce_q;
    assign ram_oe     = oe_q;
    assign ram_we     = wen_q;
    assign ram_lb     = lb_q;
    assign ram_hb     = hb_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling
// edge. "Cycle 0" of each scenario is the cycle in which requests rise.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [17:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        host_req;
    logic        host_we;
    logic [17:0] host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_be;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        busy;
    logic [17:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ACCESS_CYCLES(2), .HOST_SLOT(8)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_be(host_be), .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
    );

    // SRAM model; preload goes through the same process as bus writes.
    logic [15:0] mem [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = 18'd0;
    logic [15:0] pl_data = 16'd0;

    assign ram_din = mem[ram_addr];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (!ram_ce && !ram_we) begin
            if (!ram_lb) mem[ram_addr][7:0]  <= ram_dout[7:0];
            if (!ram_hb) mem[ram_addr][15:8] <= ram_dout[15:8];
        end
    end

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Drives one host access starting now; reports ack cycle and read data.
    task automatic host_access(input logic we, input logic [17:0] a, input logic [15:0] d,
                               input logic [1:0] be, output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 16'h0;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_be = be;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (host_ack) begin
                lat = c;
                rd  = host_rdata;
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !== 5'b11111) begin
            bad++; $display("FAIL reset_strobes: got %b want 11111", {ram_ce, ram_oe, ram_we, ram_lb, ram_hb});
        end
        total++;
        if (ram_addr !== 18'h0 || ram_dout !== 16'h0) begin
            bad++; $display("FAIL reset_bus: got addr=%h dout=%h want 0/0", ram_addr, ram_dout);
        end
        total++;
        if ({vid_ack, host_ack, busy} !== 3'b000 || vid_rdata !== 16'h0 || host_rdata !== 16'h0) begin
            bad++; $display("FAIL reset_outs: got ack=%b%b busy=%b vrd=%h hrd=%h want all 0",
                            vid_ack, host_ack, busy, vid_rdata, host_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_video_read;
        preload(18'h01234, 16'hBEEF);
        vid_req = 1'b1; vid_addr = 18'h01234;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ram_ce !== 1'b1) begin
            bad++; $display("FAIL vid_c0: got busy=%b ce=%b want 0/1", busy, ram_ce);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            total++;
            if ({ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !== 5'b00100 || ram_addr !== 18'h01234 || busy !== 1'b1) begin
                bad++; $display("FAIL vid_access c%0d: got strobes=%b addr=%h busy=%b want 00100/01234/1",
                                c, {ram_ce, ram_oe, ram_we, ram_lb, ram_hb}, ram_addr, busy);
            end
        end
        @(negedge clk);
        total++;
        if (vid_ack !== 1'b1 || vid_rdata !== 16'hBEEF || ram_ce !== 1'b1) begin
            bad++; $display("FAIL vid_ack_c3: got ack=%b rdata=%h ce=%b want 1/beef/1", vid_ack, vid_rdata, ram_ce);
        end
        @(posedge clk); #1;
        vid_req = 1'b0;
        @(negedge clk);
        total++;
        if (vid_ack !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL vid_c4: got ack=%b busy=%b want 0/0", vid_ack, busy);
        end
    endtask

    task automatic test_host_byte_write;
        preload(18'h3FFFF, 16'h1234);
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'hA55A; host_be = 2'b01;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ram_ce, ram_oe, ram_we, ram_hb, ram_lb} !== 5'b01110 || ram_dout !== 16'hA55A || ram_addr !== 18'h3FFFF) begin
            bad++; $display("FAIL bw_c1: got ce,oe,we,hb,lb=%b dout=%h addr=%h want 01110/a55a/3ffff",
                            {ram_ce, ram_oe, ram_we, ram_hb, ram_lb}, ram_dout, ram_addr);
        end
        @(negedge clk);
        total++;
        if ({ram_ce, ram_oe, ram_we, ram_hb, ram_lb} !== 5'b01010 || ram_dout !== 16'hA55A) begin
            bad++; $display("FAIL bw_c2: got ce,oe,we,hb,lb=%b dout=%h want 01010/a55a",
                            {ram_ce, ram_oe, ram_we, ram_hb, ram_lb}, ram_dout);
        end
        @(negedge clk);
        total++;
        if (host_ack !== 1'b1 || {ram_ce, ram_oe, ram_we, ram_hb, ram_lb} !== 5'b11111) begin
            bad++; $display("FAIL bw_c3: got ack=%b strobes=%b want 1/11111", host_ack, {ram_ce, ram_oe, ram_we, ram_hb, ram_lb});
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        total++;
        if (host_ack !== 1'b0 || ram_dout !== 16'hA55A) begin
            bad++; $display("FAIL bw_c4: got ack=%b dout=%h want 0 with dout held a55a", host_ack, ram_dout);
        end
        total++;
        if (mem[18'h3FFFF] !== 16'h125A) begin
            bad++; $display("FAIL bw_mem: got %h want 125a", mem[18'h3FFFF]);
        end
    endtask

    task automatic test_simultaneous;
        int va = -1;
        int ha = -1;
        preload(18'h00020, 16'h7777);
        preload(18'h00021, 16'h1111);
        vid_req = 1'b1; vid_addr = 18'h00021;
        host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00020; host_be = 2'b11;
        for (int c = 0; c < 20 && ha < 0; c++) begin
            @(negedge clk);
            if (vid_ack && va < 0) va = c;
            if (host_ack && ha < 0) ha = c;
            @(posedge clk); #1;
            if (va == c) vid_req = 1'b0;
            if (ha == c) host_req = 1'b0;
        end
        vid_req = 1'b0; host_req = 1'b0;
        total++;
        if (va !== 3) begin
            bad++; $display("FAIL sim_vid_first: vid_ack cycle %0d want 3", va);
        end
        total++;
        if (ha !== 7) begin
            bad++; $display("FAIL sim_host_next: host_ack cycle %0d want 7", ha);
        end
        total++;
        if (vid_rdata !== 16'h1111 || host_rdata !== 16'h7777) begin
            bad++; $display("FAIL sim_data: got vrd=%h hrd=%h want 1111/7777", vid_rdata, host_rdata);
        end
    endtask

    task automatic test_starvation;
        int n = 0;
        int vid_before = 0;
        int h_cyc = -1;
        logic last_is_vid = 1'b0;
        vid_req = 1'b1; vid_addr = 18'h00400;
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00100; host_wdata = 16'h0F0F; host_be = 2'b11;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clk);
            if (vid_ack) begin
                n++;
                if (h_cyc < 0) vid_before++;
                last_is_vid = 1'b1;
            end
            if (host_ack) begin
                n++;
                h_cyc = c;
                last_is_vid = 1'b0;
            end
            @(posedge clk); #1;
            if (h_cyc == c) host_req = 1'b0;
        end
        vid_req = 1'b0; host_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (vid_before !== 8) begin
            bad++; $display("FAIL starve_count: video acks before host %0d want 8", vid_before);
        end
        total++;
        if (h_cyc !== 35) begin
            bad++; $display("FAIL starve_host_cycle: host_ack cycle %0d want 35", h_cyc);
        end
        total++;
        if (n !== 10 || last_is_vid !== 1'b1) begin
            bad++; $display("FAIL starve_resume: acks=%0d last_vid=%b want 10/1", n, last_is_vid);
        end
        total++;
        if (mem[18'h00100] !== 16'h0F0F) begin
            bad++; $display("FAIL starve_mem: got %h want 0f0f", mem[18'h00100]);
        end
    endtask

    task automatic test_reset_mid_access;
        logic saw_ack = 1'b0;
        int va = -1;
        preload(18'h00200, 16'h0000);
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00200; host_wdata = 16'hFFFF; host_be = 2'b11;
        @(posedge clk); #1;
        reset = 1'b1; host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ram_ce, ram_oe, ram_we, ram_lb, ram_hb} !== 5'b11111 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_strobes: got %b busy=%b want 11111/0", {ram_ce, ram_oe, ram_we, ram_lb, ram_hb}, busy);
        end
        total++;
        if (vid_rdata !== 16'h0 || host_rdata !== 16'h0 || ram_addr !== 18'h0 || ram_dout !== 16'h0) begin
            bad++; $display("FAIL rst_mid_clear: got vrd=%h hrd=%h addr=%h dout=%h want zeros",
                            vid_rdata, host_rdata, ram_addr, ram_dout);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (host_ack) saw_ack = 1'b1;
        end
        total++;
        if (saw_ack !== 1'b0 || mem[18'h00200] !== 16'h0000) begin
            bad++; $display("FAIL rst_mid_noack: got ack_seen=%b mem=%h want 0/0000", saw_ack, mem[18'h00200]);
        end
        preload(18'h00300, 16'hCAFE);
        vid_req = 1'b1; vid_addr = 18'h00300;
        for (int c = 0; c < 20 && va < 0; c++) begin
            @(negedge clk);
            if (vid_ack) va = c;
        end
        @(posedge clk); #1;
        vid_req = 1'b0;
        total++;
        if (va !== 3 || vid_rdata !== 16'hCAFE) begin
            bad++; $display("FAIL rst_mid_after: ack cycle %0d rdata=%h want 3/cafe", va, vid_rdata);
        end
    endtask

    task automatic test_readback;
        int lat;
        logic [15:0] rd;
        host_access(1'b1, 18'h00010, 16'h1357, 2'b11, lat, rd);
        total++;
        if (lat !== 3 || mem[18'h00010] !== 16'h1357) begin
            bad++; $display("FAIL rb_write: ack cycle %0d mem=%h want 3/1357", lat, mem[18'h00010]);
        end
        host_access(1'b0, 18'h00010, 16'h0000, 2'b00, lat, rd);
        total++;
        if (lat !== 3 || rd !== 16'h1357) begin
            bad++; $display("FAIL rb_read: ack cycle %0d rdata=%h want 3/1357", lat, rd);
        end
        total++;
        if (vid_rdata !== 16'hCAFE) begin
            bad++; $display("FAIL rb_vid_hold: vid_rdata=%h want cafe", vid_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = 18'h0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 18'h0; host_wdata = 16'h0; host_be = 2'b00;
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        @(posedge clk); #1;
        test_reset;
        test_video_read;
        test_host_byte_write;
        test_simultaneous;
        test_starvation;
        test_reset_mid_access;
        test_readback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
